seq_multdiv: RTL and testbench

- Iterative signed 32-bit multiply/divide unit.
- It is the responder side of the X-stage multdiv handshake. The pipeline issues a one-cycle ctrl_MULT or ctrl_DIV pulse with operands, stalls, and waits for data_resultRDY.
- One operation is in flight at a time. The result and exception flag are held stable from RDY until the next start.

---
 rtl/seq_multdiv.sv | 106 ++++++++++
 tb/tb_seq_multdiv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multdiv.sv
// seq_multdiv: iterative signed 32-bit multiply/divide unit, multdiv handshake responder
// Ports:
//   clock          - master clock, all state changes on the rising edge
//   reset          - synchronous active-low reset
//   data_operandA  - multiplicand / dividend (two's complement)
//   data_operandB  - multiplier / divisor (two's complement)
//   ctrl_MULT      - one-cycle start pulse for a multiply
//   ctrl_DIV       - one-cycle start pulse for a divide
//   data_result    - product low word / quotient, held until the next completion
//   data_exception - overflow or divide-by-zero flag of the last completed op
//   data_resultRDY - one-cycle completion pulse
module seq_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    // Multiply: {upper(W+1), multiplier(W), booth bit}; divide: {0, remainder(W+1), quotient(W)}
    logic [2*WIDTH+1:0]   acc;
    logic [WIDTH-1:0]     opa;
    logic                 is_div;
    logic                 neg;

    logic                 start_m, start_d;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       booth_hi;
    logic [WIDTH:0]       trial;
    logic [WIDTH+1:0]     diff;
    logic                 ge;
    logic [2*WIDTH+1:0]   mul_next, div_next;
    logic [WIDTH:0]       prod_hi;
    logic [WIDTH-1:0]     quo, div_res;
    logic                 mul_exc, div_exc;

    assign start_m = ctrl_MULT & ~ctrl_DIV;
    assign start_d = ctrl_DIV & ~ctrl_MULT;
    assign mag_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Radix-2 Booth step; the upper part is one bit wider so subtracting the most negative multiplicand cannot overflow
    assign booth_hi = acc[1:0] == 2'b01 ? acc[2*WIDTH+1:WIDTH+1] + {opa[WIDTH-1], opa} :
                      acc[1:0] == 2'b10 ? acc[2*WIDTH+1:WIDTH+1] - {opa[WIDTH-1], opa} :
                                          acc[2*WIDTH+1:WIDTH+1];
    assign mul_next = {booth_hi[WIDTH], booth_hi, acc[WIDTH:1]};

    // Restoring divide step on magnitudes
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = {1'b0, trial} - {2'b00, opa};
    assign ge       = ~diff[WIDTH+1];
    assign div_next = {1'b0, ge ? diff[WIDTH:0] : trial, acc[WIDTH-2:0], ge};

    // Product bits [63:31] must be a pure sign extension for the result to fit
    assign prod_hi  = acc[2*WIDTH:WIDTH];
    assign mul_exc  = ~(&prod_hi | ~|prod_hi);

    // A non-negative quotient with the top bit set only arises from MIN/-1 (or a zero divisor)
    assign quo      = acc[WIDTH-1:0];
    assign div_res  = opa == '0 ? '0 : neg ? -quo : quo;
    assign div_exc  = opa == '0 | (~neg & quo[WIDTH-1]);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            opa            <= '0;
            is_div         <= 1'b0;
            neg            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start_m || start_d) begin
                state  <= start_m ? MUL : DIV;
                cnt    <= '0;
                is_div <= start_d;
                neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                opa    <= start_m ? data_operandA : mag_b;
                acc    <= start_m ? {(WIDTH+1)'(0), data_operandB, 1'b0} : {(WIDTH+2)'(0), mag_a};
            end else if (state == MUL || state == DIV) begin
                acc <= state == MUL ? mul_next : div_next;
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1))
                    state <= DONE;
            end else if (state == DONE) begin
                data_result    <= is_div ? div_res : acc[WIDTH:1];
                data_exception <= is_div ? div_exc : mul_exc;
                data_resultRDY <= 1'b1;
                state          <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_seq_multdiv.sv
// tb_seq_multdiv: scoreboard bench for seq_multdiv with directed and random multiply/divide ops
module tb_seq_multdiv;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    seq_multdiv dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        rst_seen = 1'b0;
    logic [31:0] hold_res = '0;
    logic        hold_exc = 1'b0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h expected=%h", n, cyc, act, exp);
        end
    endtask

    // Reference behaviour from plain signed arithmetic
    function automatic exp_t model(input bit dv, input logic [31:0] a, input logic [31:0] b);
        exp_t   x;
        longint p;
        int     sa, sb;
        sa = a;
        sb = b;
        x.due = 0;
        if (!dv) begin
            p = longint'(sa) * longint'(sb);
            x.res = p[31:0];
            x.exc = p != longint'(int'(p[31:0]));
        end else if (sb == 0) begin
            x.res = 32'h0;
            x.exc = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            x.res = 32'h80000000;
            x.exc = 1'b1;
        end else begin
            x.res = 32'(sa / sb);
            x.exc = 1'b0;
        end
        return x;
    endfunction

    // Any op that would complete at or after edge s is aborted by an event at edge s
    function automatic void drop(input int s);
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].due >= s) q.delete(i);
    endfunction

    always @(negedge clock) begin
        if (!rst_seen) begin
            chk("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
            chk("reset_result", data_result, 32'h0);
            chk("reset_exception", {31'b0, data_exception}, 32'h0);
            hold_res = '0;
            hold_exc = 1'b0;
        end else if (data_resultRDY) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rdy at cycle %0d: actual=1 expected=0", cyc);
            end else begin
                e = q.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
                chk("latency", 32'(cyc), 32'(e.due));
                hold_res = e.res;
                hold_exc = e.exc;
            end
        end else begin
            chk("hold_result", data_result, hold_res);
            chk("hold_exception", {31'b0, data_exception}, {31'b0, hold_exc});
            if (q.size() != 0 && cyc > q[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_rdy at cycle %0d: actual=0 expected=1 (due %0d)", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic issue(input bit dv, input logic [31:0] a, input logic [31:0] b);
        int   s;
        exp_t x;
        @(posedge clock);
        #2;
        s = cyc + 1;
        drop(s);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = !dv;
        ctrl_DIV = dv;
        x = model(dv, a, b);
        x.due = s + 33;
        q.push_back(x);
        @(posedge clock);
        #2;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic both_high();
        @(posedge clock);
        #2;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #2;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #2;
        reset = 1'b0;
        drop(cyc + 1);
        repeat (n) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 6))
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h0;
            4, 5: return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
        idle(40);
        issue(0, 32'd7, 32'hFFFFFFFA);
        idle(36);
        issue(0, 32'h00010000, 32'h00010000);
        idle(36);
        issue(0, 32'h00007FFF, 32'd2);
        idle(36);
        issue(1, 32'hFFFFFFF9, 32'd2);
        idle(36);
        issue(1, 32'd100, 32'd0);
        idle(36);
        issue(1, 32'h80000000, 32'hFFFFFFFF);
        idle(36);
        issue(0, 32'd3, 32'd4);
        idle(8);
        issue(1, 32'd20, 32'd5);
        idle(5);
        both_high();
        idle(36);
        both_high();
        idle(3);
        issue(1, 32'd1000, 32'd7);
        idle(13);
        do_reset(1);
        idle(5);
        issue(1, 32'd9, 32'd3);
        idle(36);
        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom_range(0, 1)), rnd(), rnd());
            k = $urandom_range(0, 9);
            if (k == 0) idle($urandom_range(0, 29));
            else if (k == 1) begin
                idle($urandom_range(0, 25));
                both_high();
                idle(36);
            end else if (k == 2) idle(30);
            else if (k == 3) idle(31);
            else idle($urandom_range(32, 36));
        end
        idle(40);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending expected=0 pending", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
